// File: rtl/gcd_pkg.sv
// gcd_pkg: shared defaults and FSM state encoding for the GCD job sequencer.
package gcd_pkg;
  localparam int GCD_WIDTH = 16;
  localparam int GCD_DEPTH = 4;
  localparam int GCD_TIMEOUT = 1023;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/gcd_req_fifo.sv
// gcd_req_fifo: synchronous request FIFO holding {a,b} operand pairs.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int DEPTH = GCD_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [2*WIDTH-1:0] i_data,
  output logic [2*WIDTH-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wp, r_rp;
  logic [2*WIDTH-1:0] r_mem [DEPTH];
  // Extra pointer MSB tells full from empty when the indices match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
  assign o_data  = r_mem[r_rp[AW-1:0]];
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: queues operand pairs and runs them one at a time through the GCD unit,
// bypassing pairs with a zero operand and aborting jobs the unit never answers.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = GCD_DEPTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_gcd_o,
  output logic             rsp_err_o,
  output logic             core_start_o,
  output logic [WIDTH-1:0] core_a_o,
  output logic [WIDTH-1:0] core_b_o,
  input  logic             core_valid_i,
  input  logic [WIDTH-1:0] core_result_i,
  output logic             busy_o
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  state_t r_state, w_next;
  logic r_init, r_err, w_err, w_pop, w_push, w_full, w_empty;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_gcd, w_a, w_b, w_gcd, w_ha, w_hb;
  assign w_push = req_valid_i & req_ready_o;
  gcd_req_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data ({req_a_i, req_b_i}),
    .o_data ({w_ha, w_hb}),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  // The counter is zero only in the first WAIT cycle, which doubles as the blanking flag.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cnt  = r_cnt;
    w_a    = r_a;
    w_b    = r_b;
    w_gcd  = r_gcd;
    w_err  = r_err;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop = 1'b1;
        if (w_ha == '0 || w_hb == '0) begin
          w_gcd  = w_ha | w_hb;
          w_err  = 1'b0;
          w_next = S_HOLD;
        end else begin
          w_a    = w_ha;
          w_b    = w_hb;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt  = '0;
        w_next = S_WAIT;
      end
      S_WAIT: if (r_cnt != '0 && core_valid_i) begin
        w_gcd  = core_result_i;
        w_err  = 1'b0;
        w_next = S_HOLD;
      end else if (r_cnt == CW'(TIMEOUT)) begin
        w_gcd  = '0;
        w_err  = 1'b1;
        w_next = S_HOLD;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
      S_HOLD: w_next = rsp_ready_i ? S_IDLE : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_init  <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gcd   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_init  <= 1'b1;
      r_cnt   <= w_cnt;
      r_a     <= w_a;
      r_b     <= w_b;
      r_gcd   <= w_gcd;
      r_err   <= w_err;
    end
  end
  assign req_ready_o  = r_init & ~w_full;
  assign rsp_valid_o  = r_state == S_HOLD;
  assign rsp_gcd_o    = r_gcd;
  assign rsp_err_o    = r_err;
  assign core_start_o = r_state == S_ISSUE;
  assign core_a_o     = r_a;
  assign core_b_o     = r_b;
  assign busy_o       = (r_state != S_IDLE) | ~w_empty;
endmodule
